// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, data width and default FIFO depth.
package uart_pkg;

    localparam int DATA_W        = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_rx.sv
// Receive FIFO: wrap-bit pointers, array storage with a registered read port.
module fifo_rx
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,  // power of two, at least 2
    parameter int W     = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  w_ptr_q, w_ptr_d;
    logic [AW:0]  r_ptr_q, r_ptr_d;
    logic [W-1:0] rd_data_q;
    logic         do_push;
    logic         do_pop;

    // Equal pointers mean empty; equal low bits with differing wrap bits mean full.
    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_ptr_q[AW] != r_ptr_q[AW]) &&
                   (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);

    // Full is judged before any same-cycle pop, so a pop never frees room for a push.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = rd_data_q;

    // Pointer advance; the extra MSB makes wrap-around seamless.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (do_push) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end
        if (do_pop) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
    end

    // Storage write port; left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[w_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Pointer registers and the registered read port (holds when not popping).
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            rd_data_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            if (do_pop) begin
                rd_data_q <= mem[r_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: input synchronizer, mid-bit sampling FSM, sticky error flags, RX FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,           // even, at least 4
    parameter int DEPTH        = DEFAULT_DEPTH // power of two
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              r_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              f_rx,
    output logic              e_rx,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rx_meta_q, rx_s_q;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push;
    logic              frame_set;
    logic              overrun_set;

    // Two-flop synchronizer on the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: start-bit validation at half a bit, then one sample per bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s_q) begin
                        frame_set = 1'b1;
                    end else if (f_rx) begin
                        overrun_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_comb begin
        frame_err_d = frame_set   || (frame_err_q && !clr_err);
        overrun_d   = overrun_set || (overrun_q   && !clr_err);
    end

    // FSM, counters, shift register and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    fifo_rx #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .pop       (r_en),
        .pop_data  (data_out),
        .full      (f_rx),
        .empty     (e_rx)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard and immediate-assertion checks.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       r_en;
    logic       clr_err;
    logic [7:0] data_out;
    logic       f_rx;
    logic       e_rx;
    logic       frame_err;
    logic       overrun;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT (16),
        .DEPTH        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .r_en      (r_en),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .f_rx      (f_rx),
        .e_rx      (e_rx),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Start bit plus eight data bits, LSB first; returns at the start of the stop bit.
    task automatic start_and_data(input logic [7:0] b);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
    endtask

    // Complete good frame followed by one idle bit time.
    task automatic send(input logic [7:0] b);
        start_and_data(b);
        rx = 1'b1;
        tick(32);
    endtask

    // One-cycle pop strobe, then compare the registered byte with the scoreboard.
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty on pop", tag);
            $fatal(1, "scoreboard underflow");
        end
        exp  = exp_q.pop_front();
        r_en = 1'b1;
        tick(1);
        r_en = 1'b0;
        check(tag, data_out, exp);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; r_en = 1'b0; clr_err = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_data_out", data_out, 8'h00);
        check("rst_e_rx", {7'd0, e_rx}, 8'd1);
        check("rst_f_rx", {7'd0, f_rx}, 8'd0);
        check("rst_frame_err", {7'd0, frame_err}, 8'd0);
        check("rst_overrun", {7'd0, overrun}, 8'd0);

        // Single good byte; e_rx must fall at the mid-stop-bit sample.
        start_and_data(8'hA5);
        exp_q.push_back(8'hA5);
        rx = 1'b1;
        tick(8);
        check("a5_e_rx_before_stop", {7'd0, e_rx}, 8'd1);
        tick(4);
        check("a5_e_rx_after_stop", {7'd0, e_rx}, 8'd0);
        tick(20);
        pop_check("a5_data");
        check("a5_e_rx_drained", {7'd0, e_rx}, 8'd1);

        // Short low glitch is rejected; receiver still works afterwards.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_e_rx", {7'd0, e_rx}, 8'd1);
        check("glitch_frame_err", {7'd0, frame_err}, 8'd0);
        check("glitch_overrun", {7'd0, overrun}, 8'd0);
        send(8'h96);
        exp_q.push_back(8'h96);
        pop_check("post_glitch_data");

        // Bad stop bit sets frame_err without a push; clr_err clears it.
        start_and_data(8'h3C);
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(32);
        check("ferr_set", {7'd0, frame_err}, 8'd1);
        check("ferr_e_rx", {7'd0, e_rx}, 8'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ferr_cleared", {7'd0, frame_err}, 8'd0);

        // clr_err on the very edge a frame error is detected: the set wins.
        start_and_data(8'h11);
        rx = 1'b0;
        tick(10);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ferr_set_wins", {7'd0, frame_err}, 8'd1);
        tick(5);
        rx = 1'b1;
        tick(32);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;

        // Nine bytes with no reads: full after eight, ninth is an overrun.
        for (int i = 1; i <= 9; i++) begin
            send(8'(i));
            if (i <= 8) exp_q.push_back(8'(i));
            if (i == 8) begin
                check("fill8_f_rx", {7'd0, f_rx}, 8'd1);
                check("fill8_overrun", {7'd0, overrun}, 8'd0);
            end
            if (i == 9) begin
                check("fill9_overrun", {7'd0, overrun}, 8'd1);
                check("fill9_f_rx", {7'd0, f_rx}, 8'd1);
            end
        end
        for (int i = 0; i < 8; i++) pop_check("full_drain");
        check("full_drain_e_rx", {7'd0, e_rx}, 8'd1);
        check("full_drain_f_rx", {7'd0, f_rx}, 8'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovr_cleared", {7'd0, overrun}, 8'd0);

        // Three entries held, then a pop lands on the same edge as a push.
        for (int i = 0; i < 3; i++) begin
            send(8'h21 + 8'(i));
            exp_q.push_back(8'h21 + 8'(i));
        end
        start_and_data(8'h24);
        exp_q.push_back(8'h24);
        rx = 1'b1;
        tick(10);
        pop_check("coincide_pop");
        tick(21);
        check("coincide_e_rx", {7'd0, e_rx}, 8'd0);
        check("coincide_f_rx", {7'd0, f_rx}, 8'd0);
        for (int i = 0; i < 3; i++) pop_check("coincide_order");
        check("coincide_e_rx_end", {7'd0, e_rx}, 8'd1);

        // Twenty bytes streamed through the FIFO, wrapping the pointers.
        for (int i = 0; i < 20; i++) begin
            send(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
            if (i >= 4) pop_check("wrap_data");
        end
        for (int i = 0; i < 4; i++) pop_check("wrap_tail");
        check("wrap_e_rx", {7'd0, e_rx}, 8'd1);

        // Reset during data bit 4 with a byte already queued.
        send(8'h77);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h5A >> i);
            tick(16);
        end
        rx = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_e_rx", {7'd0, e_rx}, 8'd1);
        check("midrst_f_rx", {7'd0, f_rx}, 8'd0);
        check("midrst_frame_err", {7'd0, frame_err}, 8'd0);
        check("midrst_overrun", {7'd0, overrun}, 8'd0);
        tick(40);
        check("midrst_no_ghost", {7'd0, e_rx}, 8'd1);
        send(8'h5A);
        exp_q.push_back(8'h5A);
        pop_check("midrst_5a");
        check("midrst_e_rx_end", {7'd0, e_rx}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
